// File: rtl/mul_issue_sched_if.sv
// mul_issue_sched_if: bundle between the two integer issue slots, the external
// writeback claimants, the shared pipelined multiplier and the issue scheduler.
//
// Parameters
//   ROB_W   ROB pointer width
//   HILO_W  HI/LO PRF pointer width
//   DLY_W   width of the claim look-ahead field, $clog2(DLY_MAX+1)
//
// Signals (direction as seen by the scheduler, modport slave)
//   req_val/req_rdy       per-requester valid and grant (bit i = issue slot i)
//   req_signed            per-requester MULT (1) / MULTU (0)
//   req_src_a/req_src_b   per-requester operands, slot i at [32i+:32]
//   req_rob/req_hilo      per-requester ROB pointer and HI/LO PRF destination
//   clm_val/clm_dly       external writeback-port claim and how far ahead it is
//   flush                 kill every multiply accepted before this cycle
//   mul_go..mul_hilo      issue to the multiplier
//   mul_complete          multiplier result strobe
//   wb_val                live multiply result, write HI/LO and retire
//   busy                  any multiply in flight
//   err                   sticky protocol error
interface mul_issue_sched_if #(
    parameter int unsigned ROB_W  = 6,
    parameter int unsigned HILO_W = 4,
    parameter int unsigned DLY_W  = 4
);
    logic [1:0]          req_val;
    logic [1:0]          req_rdy;
    logic [1:0]          req_signed;
    logic [63:0]         req_src_a;
    logic [63:0]         req_src_b;
    logic [2*ROB_W-1:0]  req_rob;
    logic [2*HILO_W-1:0] req_hilo;
    logic                clm_val;
    logic [DLY_W-1:0]    clm_dly;
    logic                flush;
    logic                mul_go;
    logic                mul_signed;
    logic [31:0]         mul_src_a;
    logic [31:0]         mul_src_b;
    logic [ROB_W-1:0]    mul_rob;
    logic [HILO_W-1:0]   mul_hilo;
    logic                mul_complete;
    logic                wb_val;
    logic                busy;
    logic                err;

    modport slave (
        input  req_val, req_signed, req_src_a, req_src_b, req_rob, req_hilo,
        input  clm_val, clm_dly, flush, mul_complete,
        output req_rdy, mul_go, mul_signed, mul_src_a, mul_src_b, mul_rob, mul_hilo,
        output wb_val, busy, err
    );

    modport master (
        output req_val, req_signed, req_src_a, req_src_b, req_rob, req_hilo,
        output clm_val, clm_dly, flush, mul_complete,
        input  req_rdy, mul_go, mul_signed, mul_src_a, mul_src_b, mul_rob, mul_hilo,
        input  wb_val, busy, err
    );
endinterface

// File: rtl/mul_issue_sched.sv
// mul_issue_sched: issue scheduler for the shared fixed-latency 32x32 multiplier.
//
// Arbitrates two issue slots onto the single multiplier go port, books the shared
// HI/LO writeback port LAT cycles ahead so a multiply never collides with other
// fixed-latency writers, and squashes in-flight results on flush (the multiplier
// itself cannot be killed).
//
// Ports
//   clk    clock
//   reset  synchronous reset, active low
//   bus    mul_issue_sched_if.slave: requester handshake, claims, flush,
//          multiplier issue/complete, wb_val, busy, err
//
// Configuration macro
//   MUL_SCHED_RR_EN  defined: round-robin between the two requesters;
//                    undefined: fixed priority, requester 0 wins.
module mul_issue_sched #(
    parameter int unsigned LAT     = 4,
    parameter int unsigned DLY_MAX = 8,
    parameter int unsigned ROB_W   = 6,
    parameter int unsigned HILO_W  = 4
) (
    input logic              clk,
    input logic              reset,
    mul_issue_sched_if.slave bus
);
    localparam int unsigned DLY_W = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0] DlyMaxC = DLY_W'(DLY_MAX);
    localparam logic [DLY_W-1:0] LatC    = DLY_W'(LAT);
    localparam logic [DLY_W-1:0] OneC    = DLY_W'(1);

    // res_q[k]: writeback port booked k cycles from now.
    // live_q/raw_q[k]: a multiply completes k cycles from now; live_q is cleared by
    // flush, raw_q is not and tracks what the multiplier will actually emit.
    logic [DLY_MAX:0] res_q, res_d;
    logic [LAT-1:0]   live_q, live_d;
    logic [LAT-1:0]   raw_q, raw_d;
    logic             err_q, err_d;

    logic             fav;
    logic             claim_ok;
    logic             claim_lat;
    logic             slot_ok;
    logic             grant_en;
    logic [1:0]       gnt;
    logic             go;
    logic             sel;

    logic             signed_win;
    logic [31:0]      a_win, b_win;
    logic [ROB_W-1:0] rob_win;
    logic [HILO_W-1:0] hilo_win;

`ifdef MUL_SCHED_RR_EN
    logic rr_q, rr_d;

    assign fav = rr_q;

    // Hand priority to the loser only when both slots were actually competing.
    always_comb begin
        rr_d = rr_q;
        if (go && (&bus.req_val)) begin
            rr_d = ~sel;
        end
    end
`else
    assign fav = 1'b0;
`endif

    // Slot check and grant.
    always_comb begin
        claim_ok  = (bus.clm_dly != '0) && (bus.clm_dly <= DlyMaxC);
        // External claims landing on our slot win; they are never stalled.
        claim_lat = bus.clm_val && (bus.clm_dly == LatC);
        slot_ok   = ~res_q[LAT] & ~claim_lat;
        grant_en  = reset & slot_ok & ~bus.flush;

        gnt = 2'b00;
        if (grant_en) begin
            if (bus.req_val[fav]) begin
                gnt[fav] = 1'b1;
            end else if (bus.req_val[~fav]) begin
                gnt[~fav] = 1'b1;
            end
        end
        go  = |gnt;
        sel = gnt[1];
    end

    // Winner's fields forwarded to the multiplier; zero when nothing issues.
    always_comb begin
        signed_win = 1'b0;
        a_win      = '0;
        b_win      = '0;
        rob_win    = '0;
        hilo_win   = '0;
        if (go) begin
            signed_win = bus.req_signed[sel];
            a_win      = sel ? bus.req_src_a[63:32] : bus.req_src_a[31:0];
            b_win      = sel ? bus.req_src_b[63:32] : bus.req_src_b[31:0];
            rob_win    = sel ? bus.req_rob[2*ROB_W-1:ROB_W] : bus.req_rob[ROB_W-1:0];
            hilo_win   = sel ? bus.req_hilo[2*HILO_W-1:HILO_W] : bus.req_hilo[HILO_W-1:0];
        end
    end

    // Booking windows slide one step toward "now" every cycle.
    always_comb begin
        res_d = res_q >> 1;
        if (bus.clm_val && claim_ok) begin
            res_d[bus.clm_dly - OneC] = 1'b1;
        end
        if (go) begin
            res_d[LAT-1] = 1'b1;
        end

        raw_d = raw_q >> 1;
        if (go) begin
            raw_d[LAT-1] = 1'b1;
        end

        // Flush drops results but leaves res/raw alone: squashed ops still occupy the port.
        live_d = bus.flush ? '0 : (live_q >> 1);
        if (go) begin
            live_d[LAT-1] = 1'b1;
        end

        // The range check is qualified by clm_val so an idle claim field is don't-care.
        err_d = err_q
              | (bus.mul_complete != raw_q[0])
              | (bus.clm_val & ~claim_ok)
              | (bus.clm_val & claim_ok & res_q[bus.clm_dly]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q  <= '0;
            live_q <= '0;
            raw_q  <= '0;
            err_q  <= 1'b0;
`ifdef MUL_SCHED_RR_EN
            rr_q   <= 1'b0;
`endif
        end else begin
            res_q  <= res_d;
            live_q <= live_d;
            raw_q  <= raw_d;
            err_q  <= err_d;
`ifdef MUL_SCHED_RR_EN
            rr_q   <= rr_d;
`endif
        end
    end

    assign bus.req_rdy    = gnt;
    assign bus.mul_go     = go;
    assign bus.mul_signed = signed_win;
    assign bus.mul_src_a  = a_win;
    assign bus.mul_src_b  = b_win;
    assign bus.mul_rob    = rob_win;
    assign bus.mul_hilo   = hilo_win;
    // wb_val/busy are forced low while reset is held, before the flops have cleared.
    assign bus.wb_val     = reset & bus.mul_complete & live_q[0];
    assign bus.busy       = reset & (|raw_q);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_mul_issue_sched.sv
module tb_mul_issue_sched;
    localparam int LAT     = 4;
    localparam int DLY_MAX = 8;
    localparam int ROB_W   = 6;
    localparam int HILO_W  = 4;
    localparam int DLY_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mul_issue_sched_if #(.ROB_W(ROB_W), .HILO_W(HILO_W), .DLY_W(DLY_W)) bus ();

    mul_issue_sched #(
        .LAT(LAT), .DLY_MAX(DLY_MAX), .ROB_W(ROB_W), .HILO_W(HILO_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Fixed-latency multiplier, reset from the same source as the scheduler.
    logic [LAT-1:0] mv;
    logic [63:0]    my [LAT];
    logic [63:0]    prod;
    logic [63:0]    mul_y;
    assign prod = bus.mul_signed
        ? 64'($signed({{32{bus.mul_src_a[31]}}, bus.mul_src_a}) *
              $signed({{32{bus.mul_src_b[31]}}, bus.mul_src_b}))
        : ({32'd0, bus.mul_src_a} * {32'd0, bus.mul_src_b});
    always @(posedge clk) begin
        if (!reset) mv <= '0;
        else        mv <= {mv[LAT-2:0], bus.mul_go};
        my[0] <= prod;
        for (int i = 1; i < LAT; i++) my[i] <= my[i-1];
    end
    assign bus.mul_complete = mv[LAT-1];
    assign mul_y = my[LAT-1];

    // Reference model: absolute-time port bookings and a list of in-flight ops.
    typedef struct {
        int issue;
        int done;
        bit live;
    } op_t;

    op_t  ops[$];
    bit   booked[int];
    int   cyc = 0;
    bit   armed = 0;
    bit   favour = 0;
    logic exp_err = 1'b0;

    always @(negedge clk) begin
        int         w;
        int         cd;
        bit         due_any, due_live, busy_e, in_rng;
        logic [1:0] rv;
        logic [1:0] e_rdy;

        rv = bus.req_val;
        cd = int'(bus.clm_dly);
        in_rng = (cd >= 1) && (cd <= DLY_MAX);
        due_any = 0;
        due_live = 0;
        foreach (ops[i]) begin
            if (ops[i].done == cyc) begin
                due_any = 1;
                if (ops[i].live) due_live = 1;
            end
        end
        busy_e = reset && (ops.size() != 0);

        w = -1;
        if (reset && !bus.flush && !booked.exists(cyc + LAT) &&
            !(bus.clm_val && cd == LAT)) begin
            if (rv == 2'b11) begin
`ifdef MUL_SCHED_RR_EN
                w = int'(favour);
`else
                w = 0;
`endif
            end else if (rv[0]) begin
                w = 0;
            end else if (rv[1]) begin
                w = 1;
            end
        end
        e_rdy = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);

        if (armed) begin
            chk("m_rdy", bus.req_rdy, e_rdy);
            chk("m_go", bus.mul_go, w >= 0);
            chk("m_a", bus.mul_src_a, (w < 0) ? 32'd0 : bus.req_src_a[w*32 +: 32]);
            chk("m_b", bus.mul_src_b, (w < 0) ? 32'd0 : bus.req_src_b[w*32 +: 32]);
            chk("m_rob", bus.mul_rob, (w < 0) ? 6'd0 : bus.req_rob[w*ROB_W +: ROB_W]);
            chk("m_hilo", bus.mul_hilo, (w < 0) ? 4'd0 : bus.req_hilo[w*HILO_W +: HILO_W]);
            if (w >= 0) chk("m_signed", bus.mul_signed, bus.req_signed[w]);
            chk("m_wb", bus.wb_val, reset && due_live && bus.mul_complete);
            chk("m_busy", bus.busy, busy_e);
            chk("m_err", bus.err, exp_err);
        end

        if (!reset) begin
            ops.delete();
            booked.delete();
            favour  = 0;
            exp_err = 1'b0;
            armed   = 1;
        end else begin
            if (bus.clm_val && !in_rng) exp_err = 1'b1;
            if (bus.clm_val && in_rng && booked.exists(cyc + cd)) exp_err = 1'b1;
            if (bus.mul_complete !== due_any) exp_err = 1'b1;
            if (bus.flush) foreach (ops[i]) ops[i].live = 0;
            if (w >= 0) begin
                booked[cyc + LAT] = 1;
                ops.push_back('{cyc, cyc + LAT, 1'b1});
                if (rv == 2'b11) favour = (w == 0);
            end
            if (bus.clm_val && in_rng) booked[cyc + cd] = 1;
            while (ops.size() > 0 && ops[0].done <= cyc) void'(ops.pop_front());
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_val = 2'b00;
        bus.clm_val = 1'b0;
        bus.clm_dly = DLY_W'(1);
        bus.flush   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        idle();
        bus.req_signed = 2'b00;
        bus.req_src_a  = {32'd11, 32'd7};
        bus.req_src_b  = {32'd5, 32'd6};
        bus.req_rob    = {6'd9, 6'd5};
        bus.req_hilo   = {4'd2, 4'd3};
        repeat (3) tick();
        reset = 1'b1;

        // Single op: 7*6 from slot 0, result four cycles later.
        bus.req_val = 2'b01;
        look();
        chk("single_rdy", bus.req_rdy, 2'b01);
        chk("single_go", bus.mul_go, 1);
        chk("single_rob", bus.mul_rob, 5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle();
            look();
            chk("single_busy", bus.busy, k <= 4);
            chk("single_wb", bus.wb_val, k == 4);
            if (k == 4) chk("single_y", mul_y, 64'd42);
        end

        // Contention, both slots held for four cycles.
        tick();
        bus.req_val = 2'b11;
        for (int k = 0; k < 4; k++) begin
            look();
`ifdef MUL_SCHED_RR_EN
            chk("cont_gnt", bus.req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("cont_gnt", bus.req_rdy, 2'b01);
`endif
            tick();
        end
        idle();
        repeat (6) tick();
        look();
        chk("cont_err", bus.err, 0);

        // Claim five ahead blocks the next cycle's issue.
        tick();
        bus.clm_val = 1'b1;
        bus.clm_dly = DLY_W'(5);
        look();
        tick();
        idle();
        bus.req_val = 2'b01;
        look();
        chk("clm_block", bus.req_rdy, 2'b00);
        tick();
        look();
        chk("clm_after", bus.req_rdy, 2'b01);
        tick();
        idle();
        repeat (6) tick();
        look();
        chk("clm_err", bus.err, 0);

        // Same-cycle claim at LAT wins over slot 1.
        tick();
        bus.clm_val = 1'b1;
        bus.clm_dly = DLY_W'(LAT);
        bus.req_val = 2'b10;
        look();
        chk("same_blk", bus.req_rdy, 2'b00);
        tick();
        bus.clm_val = 1'b0;
        bus.clm_dly = DLY_W'(1);
        look();
        chk("same_next", bus.req_rdy, 2'b10);
        tick();
        idle();
        repeat (6) tick();
        look();
        chk("same_err", bus.err, 0);

        // Flush squashes t0/t1 ops; t3 op survives, even with flush on its completion.
        tick();
        bus.req_val = 2'b01;
        look();
        chk("fl_g0", bus.req_rdy, 2'b01);
        tick();
        look();
        chk("fl_g1", bus.req_rdy, 2'b01);
        tick();
        bus.flush = 1'b1;
        look();
        chk("fl_sup", bus.req_rdy, 2'b00);
        tick();
        bus.flush = 1'b0;
        look();
        chk("fl_g3", bus.req_rdy, 2'b01);
        tick();
        bus.req_val = 2'b00;
        look();
        chk("fl_cmp4", bus.mul_complete, 1);
        chk("fl_wb4", bus.wb_val, 0);
        tick();
        look();
        chk("fl_wb5", bus.wb_val, 0);
        tick();
        look();
        chk("fl_wb6", bus.wb_val, 0);
        tick();
        bus.flush = 1'b1;
        look();
        chk("fl_wb7", bus.wb_val, 1);
        tick();
        idle();
        repeat (6) tick();
        look();
        chk("fl_err", bus.err, 0);

        // Reset mid-flight.
        tick();
        bus.req_val = 2'b01;
        look();
        chk("rst_g0", bus.req_rdy, 2'b01);
        tick();
        idle();
        look();
        tick();
        reset = 1'b0;
        look();
        chk("rst_busy2", bus.busy, 0);
        tick();
        reset = 1'b1;
        look();
        chk("rst_busy3", bus.busy, 0);
        chk("rst_err3", bus.err, 0);
        tick();
        look();
        chk("rst_wb4", bus.wb_val, 0);

        // Two claims on the same slot, one cycle apart.
        tick();
        bus.clm_val = 1'b1;
        bus.clm_dly = DLY_W'(3);
        look();
        chk("dbl_err0", bus.err, 0);
        tick();
        bus.clm_dly = DLY_W'(2);
        look();
        chk("dbl_err1", bus.err, 0);
        tick();
        idle();
        look();
        chk("dbl_err2", bus.err, 1);
        tick();
        look();
        chk("dbl_sticky", bus.err, 1);

        // Out-of-range claim delays.
        tick();
        reset = 1'b0;
        look();
        tick();
        reset = 1'b1;
        look();
        chk("rst_clr_err", bus.err, 0);
        tick();
        bus.clm_val = 1'b1;
        bus.clm_dly = DLY_W'(0);
        look();
        tick();
        idle();
        look();
        chk("dly0_err", bus.err, 1);
        tick();
        reset = 1'b0;
        look();
        tick();
        reset = 1'b1;
        bus.clm_val = 1'b1;
        bus.clm_dly = DLY_W'(9);
        look();
        tick();
        idle();
        look();
        chk("dly9_err", bus.err, 1);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
